// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (i-cache / d-cache) line-burst arbiter in front
// of a single memory port. One transaction at a time: command handshake, then
// LINE_WORDS write or read beats, then a one-cycle completion pulse.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate the winner on
// ties; otherwise the d-cache always wins a tie.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module mem_arbiter #(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req_valid,
  input  logic [1:0]                    req_write,
  input  logic [1:0][`ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0][31:0]              req_wdata,
  output logic [1:0]                    req_wdata_ready,
  output logic [1:0]                    gnt,
  output logic [31:0]                   rsp_rdata,
  output logic [1:0]                    rsp_rdata_valid,
  output logic [1:0]                    rsp_done,
  output logic                          mem_cmd_valid,
  input  logic                          mem_cmd_ready,
  output logic                          mem_cmd_write,
  output logic [`ADDR_WIDTH-1:0]        mem_cmd_addr,
  output logic [31:0]                   mem_wdata,
  output logic                          mem_wdata_valid,
  input  logic                          mem_wdata_ready,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_rdata_valid
);

  // state | meaning
  // IDLE  | no transaction; pick a winner when any request is pending
  // CMD   | present line command until memory accepts it
  // WRITE | stream LINE_WORDS write beats from the winner
  // READ  | forward LINE_WORDS read beats to the winner
  // DONE  | one-cycle completion pulse, then back to IDLE

  localparam int AW  = `ADDR_WIDTH;
  localparam int CW  = $clog2(LINE_WORDS) + 1;
  localparam int OFF = $clog2(LINE_WORDS * 4);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);
  localparam logic [AW-1:0] LINE_MASK = {AW{1'b1}} << OFF;

  if (LINE_WORDS < 1 || LINE_WORDS > 16 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line_words
    $error("mem_arbiter: LINE_WORDS must be a power of two in 1..16");
  end

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WRITE, S_READ, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  logic            win_id;
  logic            lat_write;
  logic [AW-1:0]   lat_addr;
  logic            pick;
  logic [1:0]      win_oh;

  assign win_oh = {win_id, ~win_id};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_gnt;

  assign pick = (&req_valid) ? ~last_gnt : req_valid[1];

  // Remember who was served last; starts at i-cache so the d-cache wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)
      last_gnt <= 1'b0;
    else if (state == S_DONE)
      last_gnt <= win_id;
  end
`else
  assign pick = req_valid[1];
`endif

  // Transaction sequencing: winner capture, command handshake, beat counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      win_id    <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            win_id    <= pick;
            lat_write <= req_write[pick];
            lat_addr  <= req_addr[pick] & LINE_MASK;
            beat_cnt  <= '0;
            state     <= S_CMD;
          end
        end
        S_CMD: begin
          if (mem_cmd_ready)
            state <= lat_write ? S_WRITE : S_READ;
        end
        S_WRITE: begin
          if (mem_wdata_ready) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (beat_cnt == LAST_BEAT)
              state <= S_DONE;
          end
        end
        S_READ: begin
          if (mem_rdata_valid) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (beat_cnt == LAST_BEAT)
              state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from the current state; everything is held at zero during reset.
  always_comb begin
    req_wdata_ready = '0;
    gnt             = '0;
    rsp_rdata       = '0;
    rsp_rdata_valid = '0;
    rsp_done        = '0;
    mem_cmd_valid   = 1'b0;
    mem_cmd_write   = 1'b0;
    mem_cmd_addr    = '0;
    mem_wdata       = '0;
    mem_wdata_valid = 1'b0;
    if (!rst) begin
      case (state)
        S_CMD: begin
          gnt           = win_oh;
          mem_cmd_valid = 1'b1;
          mem_cmd_write = lat_write;
          mem_cmd_addr  = lat_addr;
        end
        S_WRITE: begin
          gnt             = win_oh;
          mem_wdata       = req_wdata[win_id];
          mem_wdata_valid = 1'b1;
          if (mem_wdata_ready)
            req_wdata_ready = win_oh;
        end
        S_READ: begin
          gnt = win_oh;
          if (mem_rdata_valid) begin
            rsp_rdata       = mem_rdata;
            rsp_rdata_valid = win_oh;
          end
        end
        S_DONE: begin
          gnt      = win_oh;
          rsp_done = win_oh;
        end
        default: ;
      endcase
    end
  end

endmodule
